fig1_checker: RTL and testbench
===============================

# fig1_checker

Self-checking driver/monitor for the `fig1` AND-XOR gate block, where y = (a & b) ^ (c & d). On `start` it walks all 16 input vectors onto `a,b,c,d`, waits a programmable settle time, samples the DUT's `y`, and compares it against the reference function. It counts mismatches, latches the first failing vector, and reports pass/fail. It sits opposite the combinational block under test and replaces free-running toggle stimulus with a deterministic, clocked, self-checking sequence.

## Interface
- `SETTLE_CYCLES`, default 1: cycles spent in WAIT between driving a vector and sampling `y`; 0 allowed.
- `NUM_PASSES`, default 1: full 16-vector sweeps per run; minimum 1.
- `ERR_W`, default 8: width of the error counter.

- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  run request, sampled only in IDLE or DONE
- `y`  in  1  DUT output under check
- `a`, `b`, `c`, `d`  out  1 each  registered stimulus to DUT
- `busy`  out  1  high in APPLY/WAIT/CHECK
- `done`  out  1  high (level) in DONE
- `pass`  out  1  valid when `done`=1; 1 iff `err_count`==0
- `err_count`  out  ERR_W  mismatch count, saturating
- `first_fail`  out  4  {a,b,c,d} of the first mismatch; 0 if none
- `fail_seen`  out  1  set on the first mismatch, held until the next run

## Operation
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE with `start`=1:
  - clear `vec`, `pass_cnt`, `err_count`, `first_fail`, `fail_seen`
  - go to APPLY
- APPLY, 1 cycle:
  - {a,b,c,d} <= vec, with a as MSB
  - load settle counter
  - go to WAIT if SETTLE_CYCLES>0, else CHECK
- WAIT: decrement the counter; go to CHECK when it reaches 1.
- CHECK, 1 cycle:
  - exp = (a&b)^(c&d), computed from the registered outputs
  - on y != exp: increment `err_count`, saturating at all-ones
  - on y != exp with `fail_seen`=0: set `fail_seen`, `first_fail` <= {a,b,c,d}
  - vec==15 and pass_cnt==NUM_PASSES-1: go to DONE
  - else: vec <= vec+1 (wraps 15→0 and increments pass_cnt), go to APPLY
- DONE: hold all results; `start` begins a new run and clears results.
- `start` during `busy` is ignored.
- Mid-run reset: return to IDLE on the next edge; partial results are discarded.

## Timing
- Reset values:
  - a=b=c=d=0
  - busy=0, done=0, pass=0
  - err_count=0, first_fail=0, fail_seen=0
  - state IDLE
- Cycles per vector = SETTLE_CYCLES+2.
- Defaults: 3 cycles per vector; `done` rises 48 edges after the edge that samples `start`.
- General: `done` rises 16·NUM_PASSES·(SETTLE_CYCLES+2) edges after the start edge.
- `y` is sampled at the end of CHECK. With SETTLE_CYCLES=0, the DUT path must settle within one cycle of APPLY.
- `pass` is combinational from `err_count`, gated by `done`.
- Saturation: when `err_count` is at 2^ERR_W−1, further mismatches leave it unchanged.

## Structure
- Package `fig1_pkg`:
  - state enum `fig1_chk_state_t`
  - function `fig1_model(a,b,c,d)` returning (a&b)^(c&d), shared with any future scoreboards
  - localparam `FIG1_NUM_VEC`=16
- No sub-module inside the checker; the DUT is external.
- Bench top: `fig1_checker` instance plus a `fig1` instance wired directly to it.

## Test plan
- Defaults, correct `fig1` DUT, one `start` pulse → `done` at edge 48, pass=1, err_count=0, fail_seen=0.
- `y` tied 0 → err_count=6, first_fail=4'b0011, pass=0.
- `y` = inverted DUT output → err_count=16, first_fail=4'b0000; with ERR_W=3 → err_count=7 (saturated).
- NUM_PASSES=2, `y` tied 0 → err_count=12, `done` at edge 96; SETTLE_CYCLES=0, correct DUT → `done` at edge 32, pass=1.
- `start` re-pulsed at edge 10 while busy → ignored, `done` still at edge 48; `rst_n`=0 at edge 20 → next edge: IDLE, all outputs at reset values.
- `start` in DONE after a failing run → results cleared, second run with correct DUT → pass=1, first_fail=0.

Source files
------------

// File: rtl/fig1_pkg.sv
// Shared types and reference model for the fig1 AND-XOR block and its checker.
package fig1_pkg;

  localparam int FIG1_NUM_VEC = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } fig1_chk_state_t;

  function automatic logic fig1_model(input logic a, input logic b,
                                      input logic c, input logic d);
    return (a & b) ^ (c & d);
  endfunction

endpackage

// File: rtl/fig1.sv
// The fig1 combinational block under check: y = (a & b) ^ (c & d).
module fig1 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y
);

  assign y = (a & b) ^ (c & d);

endmodule

// File: rtl/fig1_checker.sv
// Clocked driver/monitor that sweeps all 16 fig1 input vectors and compares y against the model.
// Protocol: start is a level request honoured only in IDLE or DONE; results are held in DONE.
module fig1_checker
  import fig1_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_fail,
  output logic             fail_seen,
  output fig1_chk_state_t  dbg_state
);

  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [PASS_W-1:0] LAST_PASS   = PASS_W'(NUM_PASSES - 1);
  localparam logic [3:0]        LAST_VEC    = 4'(FIG1_NUM_VEC - 1);

  fig1_chk_state_t   state;
  logic [3:0]        vec;
  logic [PASS_W-1:0] pass_cnt;
  logic [CNT_W-1:0]  settle_cnt;
  logic              mismatch;

  // Expected value comes from the registered stimulus, so it always matches what the DUT sees.
  assign mismatch = (y != fig1_model(a, b, c, d));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec        <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      c          <= 1'b0;
      d          <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec        <= '0;
            pass_cnt   <= '0;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
            state      <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          {a, b, c, d} <= vec;
          settle_cnt   <= SETTLE_LOAD;
          state        <= (SETTLE_CYCLES > 0) ? ST_WAIT : ST_CHECK;
        end
        ST_WAIT: begin
          if (settle_cnt <= CNT_W'(1)) state <= ST_CHECK;
          else settle_cnt <= settle_cnt - CNT_W'(1);
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
            if (!fail_seen) begin
              fail_seen  <= 1'b1;
              first_fail <= {a, b, c, d};
            end
          end
          if (vec == LAST_VEC && pass_cnt == LAST_PASS) begin
            state <= ST_DONE;
          end else begin
            vec <= vec + 4'd1;
            if (vec == LAST_VEC) pass_cnt <= pass_cnt + PASS_W'(1);
            state <= ST_APPLY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_APPLY) || (state == ST_WAIT) || (state == ST_CHECK);
  assign done      = (state == ST_DONE);
  assign pass      = done && (err_count == '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_fig1_checker.sv
// Bench for fig1_checker: four parameterisations, each driving its own fig1 instance.
module tb_fig1_checker;
  import fig1_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] y_sel;  // 0: fig1 output, 1: tied 0, 2: inverted fig1 output

  logic [3:0]      a_v, b_v, c_v, d_v, fy, y_v;
  logic [3:0]      busy_v, done_v, pass_v, fs_v;
  logic [3:0][3:0] ff_v;
  logic [3:0][7:0] err_v;
  logic [7:0]      err0, err2, err3;
  logic [2:0]      err1;
  fig1_chk_state_t st_v [4];

  assign err_v = {err3, err2, {5'b0, err1}, err0};

  always_comb begin
    y_v = '0;
    for (int i = 0; i < 4; i++)
      y_v[i] = (y_sel == 2'd0) ? fy[i] : (y_sel == 2'd1) ? 1'b0 : ~fy[i];
  end

  fig1_checker u_chk0 (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y_v[0]),
    .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .d(d_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err0),
    .first_fail(ff_v[0]), .fail_seen(fs_v[0]), .dbg_state(st_v[0]));
  fig1_checker #(.ERR_W(3)) u_chk1 (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y_v[1]),
    .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .d(d_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err1),
    .first_fail(ff_v[1]), .fail_seen(fs_v[1]), .dbg_state(st_v[1]));
  fig1_checker #(.NUM_PASSES(2)) u_chk2 (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y_v[2]),
    .a(a_v[2]), .b(b_v[2]), .c(c_v[2]), .d(d_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err2),
    .first_fail(ff_v[2]), .fail_seen(fs_v[2]), .dbg_state(st_v[2]));
  fig1_checker #(.SETTLE_CYCLES(0)) u_chk3 (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y_v[3]),
    .a(a_v[3]), .b(b_v[3]), .c(c_v[3]), .d(d_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_count(err3),
    .first_fail(ff_v[3]), .fail_seen(fs_v[3]), .dbg_state(st_v[3]));

  fig1 u_f0 (.a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .d(d_v[0]), .y(fy[0]));
  fig1 u_f1 (.a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .d(d_v[1]), .y(fy[1]));
  fig1 u_f2 (.a(a_v[2]), .b(b_v[2]), .c(c_v[2]), .d(d_v[2]), .y(fy[2]));
  fig1 u_f3 (.a(a_v[3]), .b(b_v[3]), .c(c_v[3]), .d(d_v[3]), .y(fy[3]));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int done_at [4];

  typedef struct {
    logic       run;
    logic [1:0] ysel;
    int         inst;
    int         done_edge;
    int         err;
    int         ff;
    int         pass;
    int         fs;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag, input int i);
    check({tag, "_abcd"},  {a_v[i], b_v[i], c_v[i], d_v[i]}, 0);
    check({tag, "_busy"},  busy_v[i], 0);
    check({tag, "_done"},  done_v[i], 0);
    check({tag, "_pass"},  pass_v[i], 0);
    check({tag, "_err"},   err_v[i], 0);
    check({tag, "_ff"},    ff_v[i], 0);
    check({tag, "_fs"},    fs_v[i], 0);
    check({tag, "_state"}, st_v[i], ST_IDLE);
  endtask

  // Waits for every checker to leave APPLY/WAIT/CHECK, bounded.
  task automatic wait_idle();
    int k;
    k = 0;
    while (busy_v != 4'b0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy_v != 4'b0) check("idle_timeout", busy_v, 0);
  endtask

  // Pulses start (sampled by edge 0) and records the edge at which each done rises.
  // repulse_at / reset_at inject start or rst_n=0 sampled by that edge (0 = none).
  task automatic do_run(input logic [1:0] ysel, input int repulse_at, input int reset_at);
    bit all_done;
    wait_idle();
    y_sel = ysel;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) done_at[i] = -1;
    for (int k = 1; k <= 150; k++) begin
      if (k == repulse_at) start = 1'b1;
      if (k == reset_at) rst_n = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      if (k == reset_at) return;
      all_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (done_v[i] && done_at[i] < 0) done_at[i] = k;
        if (done_at[i] < 0) all_done = 1'b0;
      end
      if (all_done) break;
    end
  endtask

  initial begin
    //             run   ysel inst edge err ff   pass fs
    tbl[0]  = '{1'b1, 2'd0, 0, 48,  0,  0,   1, 0};
    tbl[1]  = '{1'b0, 2'd0, 2, 96,  0,  0,   1, 0};
    tbl[2]  = '{1'b0, 2'd0, 3, 32,  0,  0,   1, 0};
    tbl[3]  = '{1'b1, 2'd1, 0, 48,  6,  3,   0, 1};
    tbl[4]  = '{1'b0, 2'd1, 1, 48,  6,  3,   0, 1};
    tbl[5]  = '{1'b0, 2'd1, 2, 96,  12, 3,   0, 1};
    tbl[6]  = '{1'b0, 2'd1, 3, 32,  6,  3,   0, 1};
    tbl[7]  = '{1'b1, 2'd2, 0, 48,  16, 0,   0, 1};
    tbl[8]  = '{1'b0, 2'd2, 1, 48,  7,  0,   0, 1};
    tbl[9]  = '{1'b0, 2'd2, 2, 96,  32, 0,   0, 1};
    tbl[10] = '{1'b1, 2'd0, 0, 48,  0,  0,   1, 0};
    tbl[11] = '{1'b0, 2'd0, 1, 48,  0,  0,   1, 0};

    rst_n = 1'b0;
    start = 1'b0;
    y_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset", 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 12; r++) begin
      if (tbl[r].run) do_run(tbl[r].ysel, 0, 0);
      check($sformatf("r%0d_done_edge", r), done_at[tbl[r].inst], tbl[r].done_edge);
      check($sformatf("r%0d_err", r),       err_v[tbl[r].inst],   tbl[r].err);
      check($sformatf("r%0d_first_fail", r), ff_v[tbl[r].inst],   tbl[r].ff);
      check($sformatf("r%0d_pass", r),      pass_v[tbl[r].inst],  tbl[r].pass);
      check($sformatf("r%0d_fail_seen", r), fs_v[tbl[r].inst],    tbl[r].fs);
    end

    // start re-pulsed mid-run is ignored
    do_run(2'd0, 10, 0);
    check("repulse_done_edge", done_at[0], 48);
    check("repulse_pass", pass_v[0], 1);

    // start in DONE after a failing run clears results on the start edge
    do_run(2'd1, 0, 0);
    check("fail_run_err", err_v[0], 6);
    y_sel = 2'd0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_err_clr", err_v[0], 0);
    check("restart_fs_clr", fs_v[0], 0);
    check("restart_ff_clr", ff_v[0], 0);
    check("restart_busy", busy_v[0], 1);
    wait_idle();
    check("restart_pass", pass_v[0], 1);
    check("restart_ff", ff_v[0], 0);

    // mid-run reset returns to IDLE on the sampling edge
    do_run(2'd1, 0, 20);
    check_reset_state("midreset", 0);
    check("midreset_busy_all", busy_v, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
